// File: rtl/color_scaler_pipe.sv
// color_scaler_pipe: two-stage valid/ready RGB rescaler (truncate, round-saturate, replicate, 2x2 dither)
module color_scaler_pipe #(
  parameter int BPC_IN  = 4,
  parameter int BPC_OUT = 4,
  parameter int COORD_W = 8,
  parameter int SWAP_RB = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*BPC_IN-1:0]   in_rgb,
  input  logic                  in_sof,
  input  logic                  in_eol,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BPC_OUT-1:0]    red,
  output logic [BPC_OUT-1:0]    green,
  output logic [BPC_OUT-1:0]    blue,
  output logic                  out_sof,
  output logic                  out_eol
);
  localparam int D = BPC_IN - BPC_OUT;
  logic advance, acc;
  logic [COORD_W-1:0] x, y, cx, cy;
  logic [1:0] mode_q, em;
  logic s1_valid, s1_sof, s1_eol, s1_x0, s1_y0;
  logic [1:0] s1_mode, bayer;
  logic [3*BPC_IN-1:0] s1_rgb;
  logic s2_valid;
  logic [BPC_OUT-1:0] sc [3];
  assign advance   = !s2_valid || out_ready;
  assign in_ready  = advance;
  assign acc       = in_valid && advance;
  assign out_valid = s2_valid;
  assign cx        = in_sof ? '0 : x;
  assign cy        = in_sof ? '0 : y;
  assign em        = in_sof ? mode : mode_q;
  // 2x2 ordered threshold: (0,0)->0, (1,0)->2, (0,1)->3, (1,1)->1
  assign bayer     = {s1_x0 ^ s1_y0, s1_y0};
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [BPC_IN-1:0] ch;
    assign ch = s1_rgb[i*BPC_IN +: BPC_IN];
    if (D == 0) begin : g_pass
      logic unused;
      assign unused = ^{bayer, s1_mode};
      assign sc[i] = ch;
    end else if (D > 0) begin : g_shrink
      logic [BPC_IN:0] off;
      logic [BPC_OUT:0] q;
      assign off   = s1_mode == 2'd1 ? (BPC_IN+1)'(1) << (D-1) :
                     s1_mode == 2'd3 ? (BPC_IN+1)'({bayer, {D{1'b0}}} >> 2) : '0;
      assign q     = (BPC_OUT+1)'(({1'b0, ch} + off) >> D);
      assign sc[i] = s1_mode[0] ? (q[BPC_OUT] ? '1 : q[BPC_OUT-1:0]) : ch[BPC_IN-1:D];
    end else begin : g_expand
      localparam int E   = -D;
      localparam int REP = BPC_OUT / BPC_IN + 1;
      logic unused;
      assign unused = ^{bayer, s1_mode[0]};
      assign sc[i] = s1_mode[1] ? BPC_OUT'({REP{ch}} >> (REP*BPC_IN - BPC_OUT)) : {ch, {E{1'b0}}};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x        <= '0;
      y        <= '0;
      mode_q   <= '0;
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_x0    <= 1'b0;
      s1_y0    <= 1'b0;
      s1_mode  <= '0;
      s2_valid <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
    end else begin
      if (acc) begin
        x       <= in_eol ? '0 : cx + 1'b1;
        y       <= in_eol ? cy + 1'b1 : cy;
        mode_q  <= em;
        s1_rgb  <= in_rgb;
        s1_sof  <= in_sof;
        s1_eol  <= in_eol;
        s1_x0   <= cx[0];
        s1_y0   <= cy[0];
        s1_mode <= em;
      end
      if (advance) begin
        s1_valid <= in_valid;
        s2_valid <= s1_valid;
      end
      if (advance && s1_valid) begin
        red     <= SWAP_RB != 0 ? sc[2] : sc[0];
        green   <= sc[1];
        blue    <= SWAP_RB != 0 ? sc[0] : sc[2];
        out_sof <= s1_sof;
        out_eol <= s1_eol;
      end
    end
  end
endmodule
